// File: rtl/exhaustive_stim_capture.sv
// exhaustive_stim_capture: exhaustive input sweep of a single-output DUT with truth-table capture and drain
//
// Ports:
//   CK          clock, all state changes on the rising edge
//   reset       synchronous active-high reset
//   start       begin a sweep (only honoured while idle)
//   N_out       pattern driven onto the DUT inputs, N_out[0] is the MSB
//   dut_out     DUT single-bit response
//   busy        high from APPLY through DONE
//   done        one-cycle pulse after the last drained entry
//   rd_valid    drain entry valid
//   rd_ready    downstream accepts the current entry
//   rd_pattern  pattern index of the current drain entry
//   rd_response captured response for rd_pattern
//   truth_table bit i holds the response sampled for pattern i
//   ones_count  number of 1 responses in the sweep
module exhaustive_stim_capture #(
    parameter int N_WIDTH       = 3,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                    CK,
    input  logic                    reset,
    input  logic                    start,
    output logic [0:N_WIDTH-1]      N_out,
    input  logic                    dut_out,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [N_WIDTH-1:0]      rd_pattern,
    output logic                    rd_response,
    output logic [(1<<N_WIDTH)-1:0] truth_table,
    output logic [N_WIDTH:0]        ones_count
);
    localparam int DEPTH = 1 << N_WIDTH;
    localparam int SW    = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_APPLY = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [N_WIDTH-1:0] PAT_LAST    = '1;
    localparam logic [SW-1:0]      SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    logic [1:0]         state_q, state_d;
    logic [N_WIDTH-1:0] pat_q, pat_d;
    logic [N_WIDTH-1:0] idx_q, idx_d;
    logic [SW-1:0]      settle_q, settle_d;
    logic [DEPTH-1:0]   tt_q, tt_d;
    logic [N_WIDTH:0]   ones_q, ones_d;

    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        tt_d     = tt_q;
        ones_d   = ones_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_APPLY;
                    pat_d    = '0;
                    idx_d    = '0;
                    settle_d = '0;
                    tt_d     = '0;
                    ones_d   = '0;
                end
            end
            S_APPLY: begin
                if (settle_q == SETTLE_LAST) begin
                    tt_d[pat_q] = dut_out;
                    ones_d      = ones_q + {{N_WIDTH{1'b0}}, dut_out};
                    // The final pattern stays on N_out through DRAIN, so the
                    // pattern counter never wraps back to 0 inside a sweep.
                    if (pat_q == PAT_LAST) begin
                        state_d = S_DRAIN;
                    end else begin
                        pat_d    = pat_q + 1'b1;
                        settle_d = '0;
                    end
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (rd_ready) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == PAT_LAST) state_d = S_DONE;
                end
            end
            default: begin
                // DONE: return the DUT inputs to pattern 0 for the idle period.
                state_d = S_IDLE;
                pat_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CK) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pat_q    <= '0;
            idx_q    <= '0;
            settle_q <= '0;
            tt_q     <= '0;
            ones_q   <= '0;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            tt_q     <= tt_d;
            ones_q   <= ones_d;
        end
    end

    assign N_out       = pat_q;
    assign busy        = state_q != S_IDLE;
    assign done        = state_q == S_DONE;
    assign rd_valid    = state_q == S_DRAIN;
    assign rd_pattern  = idx_q;
    assign rd_response = rd_valid & tt_q[idx_q];
    assign truth_table = tt_q;
    assign ones_count  = ones_q;
endmodule

// File: tb/tb_exhaustive_stim_capture.sv
// tb_exhaustive_stim_capture: randomized self-checking bench for exhaustive_stim_capture
module tb_exhaustive_stim_capture;
    localparam int N = 3;
    localparam int D = 8;

    logic CK = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic rd_ready = 1'b0;
    logic sel = 1'b0;
    logic [D-1:0] fn = '0;

    logic [0:N-1] n_a, n_b;
    logic dout_a, dout_b, busy_a, busy_b, done_a, done_b, v_a, v_b, resp_a, resp_b;
    logic [N-1:0] pat_a, pat_b;
    logic [D-1:0] tt_a, tt_b;
    logic [N:0] ones_a, ones_b;

    assign dout_a = fn[n_a];
    assign dout_b = fn[n_b];

    exhaustive_stim_capture #(.N_WIDTH(N), .SETTLE_CYCLES(1)) dut_a (
        .CK(CK), .reset(reset), .start(start), .N_out(n_a), .dut_out(dout_a),
        .busy(busy_a), .done(done_a), .rd_valid(v_a), .rd_ready(rd_ready),
        .rd_pattern(pat_a), .rd_response(resp_a), .truth_table(tt_a), .ones_count(ones_a)
    );

    exhaustive_stim_capture #(.N_WIDTH(N), .SETTLE_CYCLES(3)) dut_b (
        .CK(CK), .reset(reset), .start(start), .N_out(n_b), .dut_out(dout_b),
        .busy(busy_b), .done(done_b), .rd_valid(v_b), .rd_ready(rd_ready),
        .rd_pattern(pat_b), .rd_response(resp_b), .truth_table(tt_b), .ones_count(ones_b)
    );

    logic [N-1:0] n_o, pat_o;
    logic busy_o, done_o, v_o, resp_o;
    logic [D-1:0] tt_o;
    logic [N:0] ones_o;
    logic [21:0] all_o;

    assign n_o    = sel ? n_b : n_a;
    assign pat_o  = sel ? pat_b : pat_a;
    assign busy_o = sel ? busy_b : busy_a;
    assign done_o = sel ? done_b : done_a;
    assign v_o    = sel ? v_b : v_a;
    assign resp_o = sel ? resp_b : resp_a;
    assign tt_o   = sel ? tt_b : tt_a;
    assign ones_o = sel ? ones_b : ones_a;
    assign all_o  = {n_o, busy_o, done_o, v_o, pat_o, resp_o, tt_o, ones_o};

    always #5 CK = ~CK;

    int checks = 0;
    int errors = 0;

    task automatic tick;
        @(posedge CK);
        #1;
    endtask

    // Full sweep against the model: the table fn is the DUT function, so the
    // captured truth table must equal it and the drain must list it in order.
    task automatic run_sweep(input logic [D-1:0] tbl, input int rmode, input bit hold_start, input string tag);
        int hold;
        int idx;
        int cyc;
        bit r;
        logic [N:0] exp_ones;
        hold = sel ? 3 : 1;
        exp_ones = ($countones(tbl));
        fn = tbl;
        start = 1'b1;
        tick();
        if (!hold_start) start = 1'b0;
        checks++;
        if (busy_o !== 1'b1 || n_o !== '0)
            begin errors++; $display("FAIL %s start: busy=%b n_out=%0d, need busy=1 n_out=0", tag, busy_o, n_o); end
        for (int p = 0; p < D; p++) begin
            for (int c = 0; c < hold; c++) begin
                checks++;
                if (n_o !== p[N-1:0] || v_o !== 1'b0)
                    begin errors++; $display("FAIL %s apply p=%0d c=%0d: n_out=%0d valid=%b", tag, p, c, n_o, v_o); end
                tick();
            end
        end
        idx = 0;
        cyc = 0;
        while (idx < D && cyc < 64) begin
            checks++;
            if (v_o !== 1'b1 || pat_o !== idx[N-1:0] || resp_o !== tbl[idx] || n_o !== 3'd7)
                begin errors++; $display("FAIL %s drain idx=%0d: valid=%b pat=%0d resp=%b n_out=%0d, need resp=%b", tag, idx, v_o, pat_o, resp_o, n_o, tbl[idx]); end
            r = rmode == 0 ? 1'b1 : rmode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            rd_ready = r;
            tick();
            if (r) idx++;
            cyc++;
        end
        rd_ready = 1'b0;
        checks++;
        if (idx < D)
            begin errors++; $display("FAIL %s drain timeout: accepted %0d of %0d", tag, idx, D); end
        if (rmode == 0) begin
            checks++;
            if (cyc !== D)
                begin errors++; $display("FAIL %s drain length: %0d cycles, need %0d", tag, cyc, D); end
        end
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b1 || v_o !== 1'b0 || tt_o !== tbl || ones_o !== exp_ones)
            begin errors++; $display("FAIL %s done: done=%b busy=%b valid=%b tt=%h ones=%0d, need tt=%h ones=%0d", tag, done_o, busy_o, v_o, tt_o, ones_o, tbl, exp_ones); end
        tick();
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || n_o !== '0 || tt_o !== tbl || ones_o !== exp_ones)
            begin errors++; $display("FAIL %s idle: done=%b busy=%b n_out=%0d tt=%h ones=%0d", tag, done_o, busy_o, n_o, tt_o, ones_o); end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (all_o !== '0) begin errors++; $display("FAIL reset outputs: %h, need 0", all_o); end
        reset = 1'b0;
        tick();
        checks++;
        if (all_o !== '0) begin errors++; $display("FAIL idle without start: %h, need 0", all_o); end
    endtask

    task automatic test_parity;
        logic [D-1:0] tbl;
        for (int p = 0; p < D; p++) tbl[p] = ^p[N-1:0];
        run_sweep(tbl, 0, 1'b0, "parity");
        checks++;
        if (tt_o !== 8'h96) begin errors++; $display("FAIL parity table: %h, need 96", tt_o); end
    endtask

    task automatic test_settle;
        logic [D-1:0] tbl;
        for (int p = 0; p < D; p++) tbl[p] = p[N-1];
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sel = 1'b1;
        run_sweep(tbl, 0, 1'b0, "settle");
        checks++;
        if (tt_o !== 8'hF0 || ones_o !== 4'd4) begin errors++; $display("FAIL settle table: %h ones=%0d, need f0 4", tt_o, ones_o); end
        sel = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_backpressure;
        run_sweep(D'($urandom), 1, 1'b0, "bp_toggle");
        run_sweep(D'($urandom), 2, 1'b0, "bp_random");
    endtask

    task automatic test_reset_mid_apply;
        fn = D'($urandom);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        checks++;
        if (n_o !== 3'd5 || busy_o !== 1'b1) begin errors++; $display("FAIL mid_apply pos: n_out=%0d busy=%b, need 5 1", n_o, busy_o); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (all_o !== '0) begin errors++; $display("FAIL mid_apply reset: %h, need 0", all_o); end
        run_sweep(D'($urandom), 0, 1'b0, "after_apply_reset");
    endtask

    task automatic test_reset_mid_drain;
        fn = D'($urandom) | 8'h01;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (D) tick();
        rd_ready = 1'b1;
        repeat (3) tick();
        rd_ready = 1'b0;
        checks++;
        if (v_o !== 1'b1 || pat_o !== 3'd3) begin errors++; $display("FAIL mid_drain pos: valid=%b pat=%0d, need 1 3", v_o, pat_o); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (all_o !== '0) begin errors++; $display("FAIL mid_drain reset: %h, need 0", all_o); end
    endtask

    task automatic test_start_filter;
        run_sweep(D'($urandom), 0, 1'b1, "start_held");
        tick();
        checks++;
        if (busy_o !== 1'b1 || n_o !== '0 || tt_o !== '0) begin errors++; $display("FAIL restart: busy=%b n_out=%0d tt=%h, need 1 0 0", busy_o, n_o, tt_o); end
        tick();
        checks++;
        if (n_o !== 3'd1) begin errors++; $display("FAIL restart advance: n_out=%0d, need 1", n_o); end
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL reset with start: busy=%b, need 0", busy_o); end
        reset = 1'b0;
        start = 1'b0;
        tick();
        checks++;
        if (all_o !== '0) begin errors++; $display("FAIL after reset+start: %h, need 0", all_o); end
    endtask

    task automatic test_constant;
        run_sweep(8'hFF, 2, 1'b0, "const_one");
        checks++;
        if (ones_o !== 4'd8) begin errors++; $display("FAIL const_one count: %0d, need 8", ones_o); end
        run_sweep(8'h00, 0, 1'b0, "const_zero");
    endtask

    task automatic test_random;
        repeat (4) run_sweep(D'($urandom), 2, 1'b0, "random");
    endtask

    initial begin
        test_reset();
        test_parity();
        test_settle();
        test_backpressure();
        test_reset_mid_apply();
        test_reset_mid_drain();
        test_start_filter();
        test_constant();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
